// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART register-bus arbiter.
package uart_arb_pkg;

  localparam int unsigned ADDR_W         = 11;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BE_W           = 4;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned TO_CYC_DEFAULT = 255;

  localparam logic [DATA_W-1:0] TO_RDATA = 32'hDEAD_0BAD;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Downstream request payload (everything but cs).
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } reg_req_t;

endpackage

// File: rtl/uart_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that was not granted last (last = index of previous winner).
module uart_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_reg_arb.sv
// Arbitrates two requesters onto one UART register bus; responses pass through
// combinationally to the granted side. Optional busy timeout: UART_ARB_TIMEOUT_EN.
module uart_reg_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned TO_CYC = TO_CYC_DEFAULT
) (
  input  logic              app_clk,
  input  logic              reset_ssn,
  input  logic              req0_cs,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [BE_W-1:0]   req0_be,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_ack,
  output logic              req0_err,
  input  logic              req1_cs,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [BE_W-1:0]   req1_be,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_ack,
  output logic              req1_err,
  output logic              reg_cs,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [BE_W-1:0]   reg_be,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  input  logic              reg_err,
  output logic [1:0]        arb_gnt,
  output logic              arb_busy
);

  if (TO_CYC < 1 || TO_CYC > (2**CNT_W) - 1) begin : g_to_cyc_range
    $error("TO_CYC must fit the 8-bit timeout counter");
  end

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d, rr_gnt;
  logic              last_q, last_d;
  reg_req_t          req0_p, req1_p, sel_p;
  logic              busy, gcs, ack_ok, to_hit, resp, err_v;
  logic [DATA_W-1:0] rdata_v;
`ifdef UART_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  assign req0_p   = '{wr: req0_wr, addr: req0_addr, wdata: req0_wdata, be: req0_be};
  assign req1_p   = '{wr: req1_wr, addr: req1_addr, wdata: req1_wdata, be: req1_be};
  assign arb_gnt  = gnt_q;
  assign arb_busy = busy;

  uart_arb_rr u_rr (
    .req  ({req1_cs, req0_cs}),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // Bus mirroring, response routing and next-state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    busy    = (state_q == BUSY);
    sel_p   = gnt_q[1] ? req1_p : req0_p;
    gcs     = gnt_q[1] ? req1_cs : req0_cs;
    ack_ok  = busy & gcs & reg_ack;
    to_hit  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    to_hit  = busy & gcs & ~reg_ack & (cnt_q == CNT_W'(TO_CYC));
`endif
    resp    = ack_ok | to_hit;
    err_v   = ack_ok ? reg_err : to_hit;
    rdata_v = ack_ok ? reg_rdata : (to_hit ? TO_RDATA : '0);

    reg_cs  = busy & gcs & ~to_hit;
    {reg_wr, reg_addr, reg_wdata, reg_be} = busy ? sel_p : '0;

    req0_ack   = resp & gnt_q[0];
    req1_ack   = resp & gnt_q[1];
    req0_err   = err_v & gnt_q[0];
    req1_err   = err_v & gnt_q[1];
    req0_rdata = gnt_q[0] ? rdata_v : '0;
    req1_rdata = gnt_q[1] ? rdata_v : '0;

    case (state_q)
      IDLE: begin
        if (req0_cs | req1_cs) begin
          state_d = BUSY;
          gnt_d   = rr_gnt;
          last_d  = rr_gnt[1];
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // Abort (cs dropped), normal ack and timeout all release the bus.
        if (!gcs || resp) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_reg_arb.sv
// Randomized and directed bench for uart_reg_arb against a transaction-level
// ownership model (who owns the bus, who won last, how long it has waited).
module tb_uart_reg_arb;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO    = 8;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO    = 255;
  localparam bit          TO_EN = 1'b0;
`endif

  logic        app_clk = 1'b0;
  logic        reset_ssn;
  logic        req0_cs, req0_wr, req1_cs, req1_wr;
  logic [10:0] req0_addr, req1_addr, reg_addr;
  logic [31:0] req0_wdata, req1_wdata, reg_wdata;
  logic [3:0]  req0_be, req1_be, reg_be;
  logic [31:0] req0_rdata, req1_rdata, reg_rdata;
  logic        req0_ack, req0_err, req1_ack, req1_err;
  logic        reg_cs, reg_wr, reg_ack, reg_err;
  logic [1:0]  arb_gnt;
  logic        arb_busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owner -1 = bus free, last = previous winner index.
  int m_owner = -1;
  int m_last  = 1;
  int m_cnt   = 0;
  logic ack_seen0 = 1'b0, ack_seen1 = 1'b0;

  always #5 app_clk = ~app_clk;

  uart_reg_arb #(.TO_CYC(TO)) dut (
    .app_clk(app_clk), .reset_ssn(reset_ssn),
    .req0_cs(req0_cs), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_rdata(req0_rdata),
    .req0_ack(req0_ack), .req0_err(req0_err),
    .req1_cs(req1_cs), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_rdata(req1_rdata),
    .req1_ack(req1_ack), .req1_err(req1_err),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .reg_err(reg_err),
    .arb_gnt(arb_gnt), .arb_busy(arb_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  task automatic clear_inputs();
    {req0_cs, req0_wr, req0_addr, req0_wdata, req0_be} = '0;
    {req1_cs, req1_wr, req1_addr, req1_wdata, req1_be} = '0;
    {reg_rdata, reg_ack, reg_err} = '0;
  endtask

  task automatic do_reset();
    reset_ssn = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_ssn = 1'b1;
  endtask

  // Predict every output from the model and the inputs of this cycle.
  always @(negedge app_clk) begin
    logic        busy, gcs, to, ackg, err;
    logic [1:0]  egnt;
    logic [47:0] ebus;
    logic [31:0] rd;
    busy = reset_ssn && (m_owner >= 0);
    gcs  = (m_owner == 0) ? req0_cs : req1_cs;
    to   = TO_EN && busy && gcs && !reg_ack && (m_cnt == int'(TO));
    ackg = busy && gcs && (reg_ack || to);
    err  = ackg && (reg_ack ? reg_err : 1'b1);
    rd   = !ackg ? 32'h0 : (reg_ack ? reg_rdata : 32'hDEAD_0BAD);
    egnt = !busy ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    ebus = !busy ? 48'h0 : ((m_owner == 0) ? {req0_wr, req0_addr, req0_wdata, req0_be}
                                           : {req1_wr, req1_addr, req1_wdata, req1_be});
    check_eq("arb_gnt", 64'(arb_gnt), 64'(egnt));
    check_eq("arb_busy", 64'(arb_busy), 64'(busy));
    check_eq("reg_cs", 64'(reg_cs), 64'(busy && gcs && !to));
    check_eq("reg_bus", 64'({reg_wr, reg_addr, reg_wdata, reg_be}), 64'(ebus));
    check_eq("req0_rsp", 64'({req0_ack, req0_err, req0_rdata}),
             (egnt[0]) ? 64'({ackg, err, rd}) : 64'h0);
    check_eq("req1_rsp", 64'({req1_ack, req1_err, req1_rdata}),
             (egnt[1]) ? 64'({ackg, err, rd}) : 64'h0);
    ack_seen0 = req0_ack;
    ack_seen1 = req1_ack;
  end

  always @(posedge app_clk) begin
    int  w;
    logic gcs;
    if (!reset_ssn) begin
      m_owner <= -1;
      m_last  <= 1;
      m_cnt   <= 0;
    end else if (m_owner < 0) begin
      if (req0_cs || req1_cs) begin
        w = (req0_cs && req1_cs) ? ((m_last == 1) ? 0 : 1) : (req0_cs ? 0 : 1);
        m_owner <= w;
        m_last  <= w;
        m_cnt   <= 0;
      end
    end else begin
      gcs = (m_owner == 0) ? req0_cs : req1_cs;
      if (!gcs || reg_ack || (TO_EN && m_cnt == int'(TO))) m_owner <= -1;
      else m_cnt <= m_cnt + 1;
    end
  end

  initial begin
    do_reset();
    check_eq("rst_gnt", 64'(arb_gnt), 64'h0);

    // Write from req0, downstream acks in the third BUSY cycle.
    req0_cs = 1'b1; req0_wr = 1'b1; req0_addr = 11'h044; req0_wdata = 32'hA5; req0_be = 4'hF;
    tick();
    check_eq("wr_cs", 64'(reg_cs), 64'h1);
    check_eq("wr_addr", 64'(reg_addr), 64'h044);
    tick();
    tick();
    reg_ack = 1'b1;
    #1;
    check_eq("wr_ack0", 64'(req0_ack), 64'h1);
    check_eq("wr_ack1", 64'(req1_ack), 64'h0);
    tick();
    clear_inputs();
    tick();

    // Contention from reset alternates 0,1,0,1.
    do_reset();
    req0_cs = 1'b1; req1_cs = 1'b1; reg_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rr_order", 64'(arb_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    clear_inputs();
    tick();

    // Read response with error passes through only in the ack cycle.
    do_reset();
    req1_cs = 1'b1;
    tick();
    reg_ack = 1'b1; reg_rdata = 32'h0000_005A; reg_err = 1'b1;
    #1;
    check_eq("rd_data", 64'(req1_rdata), 64'h5A);
    check_eq("rd_err", 64'(req1_err), 64'h1);
    check_eq("rd_other", 64'(req0_rdata), 64'h0);
    tick();
    req1_cs = 1'b0; reg_ack = 1'b0;
    #1;
    check_eq("rd_idle", 64'(req1_rdata), 64'h0);
    clear_inputs();
    tick();

    // req1 aborts two cycles into BUSY; next tie goes to req0.
    do_reset();
    req1_cs = 1'b1;
    tick();
    tick();
    tick();
    req1_cs = 1'b0;
    #1;
    check_eq("abort_ack", 64'(req1_ack), 64'h0);
    tick();
    check_eq("abort_idle", 64'(arb_busy), 64'h0);
    req0_cs = 1'b1; req1_cs = 1'b1;
    tick();
    check_eq("abort_next", 64'(arb_gnt), 64'h1);
    clear_inputs();
    tick();
    tick();

`ifdef UART_ARB_TIMEOUT_EN
    // No downstream ack: timeout response after TO waiting cycles.
    do_reset();
    req0_cs = 1'b1;
    tick();
    repeat (TO) tick();
    check_eq("to_rsp", 64'({req0_ack, req0_err, req0_rdata}), 64'({1'b1, 1'b1, 32'hDEAD_0BAD}));
    check_eq("to_cs", 64'(reg_cs), 64'h0);
    tick();
    check_eq("to_cs_next", 64'(reg_cs), 64'h0);
    clear_inputs();
    tick();
    tick();
`endif

    // Reset mid-BUSY drops everything at once; req0 wins first afterwards.
    req1_cs = 1'b1;
    tick();
    #2;
    reset_ssn = 1'b0;
    #1;
    check_eq("arst_cs", 64'(reg_cs), 64'h0);
    check_eq("arst_gnt", 64'(arb_gnt), 64'h0);
    check_eq("arst_ack", 64'({req0_ack, req1_ack}), 64'h0);
    tick();
    tick();
    reset_ssn = 1'b1;
    req0_cs = 1'b1;
    tick();
    check_eq("arst_first", 64'(arb_gnt), 64'h1);
    clear_inputs();
    tick();

    // Random traffic: hold until acked, occasional aborts and hold-through-ack.
    for (int c = 0; c < 1500; c++) begin
      if (!req0_cs) begin
        if ($urandom_range(2) == 0) begin
          req0_cs = 1'b1; req0_wr = 1'($urandom); req0_addr = 11'($urandom);
          req0_wdata = $urandom; req0_be = 4'($urandom);
        end
      end else if (ack_seen0) req0_cs = 1'($urandom_range(1));
      else if ($urandom_range(15) == 0) req0_cs = 1'b0;
      if (!req1_cs) begin
        if ($urandom_range(2) == 0) begin
          req1_cs = 1'b1; req1_wr = 1'($urandom); req1_addr = 11'($urandom);
          req1_wdata = $urandom; req1_be = 4'($urandom);
        end
      end else if (ack_seen1) req1_cs = 1'($urandom_range(1));
      else if ($urandom_range(15) == 0) req1_cs = 1'b0;
      reg_ack   = ($urandom_range(5) == 0);
      reg_err   = 1'($urandom);
      reg_rdata = $urandom;
      tick();
    end

    clear_inputs();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
